adder_rr_sched: RTL and testbench
=================================

Name: adder_rr_sched

Overview:
Round-robin scheduler that shares one registered adder among N_REQ requesters. It accepts one operand pair at a time from the winning requester and drives the adder's a/b/valid inputs. It captures the adder's c output after a fixed latency and returns the sum on a single response channel tagged with the requester index. It sits between the requester agents and the adder, and drives the adder ports directly.

Parameters:
N_REQ, 4, number of requesters (2..8)
DW, 4, operand width; sum width is DW+1
ADD_LAT, 1, cycles from an add_valid cycle to c valid at the adder output (>=1; elaboration assertion)
IDW, 2, requester index width = $clog2(N_REQ)

Ports:
clk  in  1  clock, all logic on posedge
reset  in  1  asynchronous, active-low reset
req_valid  in  N_REQ  per-requester operand pair valid
req_a  in  N_REQ*DW  packed operand A, slice i belongs to requester i
req_b  in  N_REQ*DW  packed operand B
req_ready  out  N_REQ  one-hot accept; request i transfers when req_valid[i] & req_ready[i]
add_a  out  DW  adder operand A
add_b  out  DW  adder operand B
add_valid  out  1  adder operand valid
add_c  in  DW+1  adder result
rsp_valid  out  1  response valid
rsp_id  out  IDW  index of the requester that owns the response
rsp_c  out  DW+1  sum
rsp_ready  in  1  response consumer ready
busy  out  1  high in any state other than IDLE
ops_done  out  16  count of completed responses; wraps 0xFFFF->0

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; rr pointer=0; all outputs 0, including req_ready, add_valid, add_a, add_b, rsp_valid, rsp_id, rsp_c, busy and ops_done. An in-flight operation is dropped, and add_valid falls immediately without waiting for a clock edge.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant = the first i with req_valid[i]=1, searching circularly from the pointer.
  - req_ready[grant] is driven combinationally high in the same cycle; all other bits are 0.
  - On that edge: latch a/b/id and set ptr = (grant+1) mod N_REQ, wrapping from N_REQ-1 to 0. Go to ISSUE.
  - With no req_valid: stay in IDLE; ptr is unchanged.
- ISSUE: add_valid=1 for exactly one cycle, with add_a/add_b = latched operands. Load the wait counter with ADD_LAT. Go to WAIT.
- WAIT:
  - add_valid=0. Decrement the counter each cycle.
  - On the edge ending the ADD_LAT-th WAIT cycle, capture add_c into rsp_c, and the latched id into rsp_id. Go to RESP.
- RESP:
  - rsp_valid=1, and rsp_id/rsp_c stay stable until rsp_ready=1.
  - On the handshake edge: rsp_valid goes to 0, ops_done increments, and the state goes to IDLE.
  - The next grant can occur in the cycle immediately after the handshake.
- Latency: accept in cycle T -> add_valid in T+1 -> rsp_valid first high in T+2+ADD_LAT (T+3 by default). Peak throughput is one op every ADD_LAT+3 cycles.
- Only one operation is outstanding. req_ready is 0 in every non-IDLE state, so a stalled response (rsp_ready=0) back-pressures all requesters indefinitely.
- Requesters must hold req_valid and operands stable until accepted. A requester that drops req_valid before its grant is simply skipped.
- Arithmetic: none inside the block. rsp_c is the adder's DW+1-bit result, passed through unmodified, so the carry-out is preserved (e.g., 15+15=30).
- add_a/add_b hold their last value outside ISSUE. Only add_valid qualifies them.

Decomposition:
- Package adder_sched_pkg:
  - state enum sched_state_e {IDLE, ISSUE, WAIT, RESP};
  - default DW/N_REQ constants;
  - typedef of the response struct {id, c}.
- Sub-module rr_arbiter (N_REQ): combinational grant from req vector plus pointer; registered pointer update on an accept strobe. The scheduler FSM instantiates it once.

Test Plan:
- Single request: requester 2, a=4'd3, b=4'd5, rsp_ready=1 -> req_ready=4'b0100 at T; add_valid in T+1 with a=3, b=5; rsp_valid at T+3 with rsp_id=2, rsp_c=8; ops_done=1.
- Overflow: a=15, b=15 from requester 0 -> rsp_c=5'd30, rsp_id=0.
- Contention: all four req_valid high continuously, ptr=0 after reset -> grant order 0,1,2,3,0. Requests are accepted every 4 cycles, and rsp_id follows the same sequence.
- Back-pressure: rsp_ready=0 for 10 cycles while requesters 1 and 3 wait -> rsp_valid held with stable data, req_ready stays 0, busy=1. After rsp_ready=1, the next grant goes to the requester after the previous id.
- Wrap-around: only requesters 3 and 0 request, ptr=3 -> grant 3, then 0, then 3.
- Reset mid-op: assert reset during WAIT -> add_valid, rsp_valid, busy and ops_done go to 0 immediately. After release, the next request is granted from ptr=0, and no stale response appears.

Source files
------------

// File: rtl/adder_rr_sched_pkg.sv
// adder_sched_pkg: shared types and default sizes for the round-robin adder scheduler
package adder_sched_pkg;
  localparam int N_REQ_DEF = 4;
  localparam int DW_DEF = 4;
  localparam int IDW_DEF = $clog2(N_REQ_DEF);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} sched_state_e;
  typedef struct packed {
    logic [IDW_DEF-1:0] id;
    logic [DW_DEF:0] c;
  } rsp_t;
endpackage

// File: rtl/adder_rr_sched_if.sv
// adder_rr_sched_if: requester, adder and response channels of the scheduler
interface adder_rr_sched_if import adder_sched_pkg::*; #(
  parameter int N_REQ = N_REQ_DEF,
  parameter int DW = DW_DEF,
  parameter int IDW = $clog2(N_REQ)
);
  logic [N_REQ-1:0] req_valid;
  logic [N_REQ-1:0] req_ready;
  logic [N_REQ*DW-1:0] req_a;
  logic [N_REQ*DW-1:0] req_b;
  logic [DW-1:0] add_a;
  logic [DW-1:0] add_b;
  logic add_valid;
  logic [DW:0] add_c;
  logic rsp_valid;
  logic rsp_ready;
  logic [IDW-1:0] rsp_id;
  logic [DW:0] rsp_c;
  modport slave (
    input req_valid, req_a, req_b, add_c, rsp_ready,
    output req_ready, add_a, add_b, add_valid, rsp_valid, rsp_id, rsp_c
  );
  modport master (
    output req_valid, req_a, req_b, add_c, rsp_ready,
    input req_ready, add_a, add_b, add_valid, rsp_valid, rsp_id, rsp_c
  );
endinterface

// File: rtl/adder_rr_sched_rr_arbiter.sv
// rr_arbiter: circular first-valid grant from a pointer that advances past each accepted grant
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDW = $clog2(N_REQ)
) (
  input  logic clk,
  input  logic reset,
  input  logic [N_REQ-1:0] req,
  input  logic accept,
  output logic any,
  output logic [IDW-1:0] grant
);
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] idx;
  // scan from farthest to nearest so the last hit is the closest to ptr
  always_comb begin
    any = 1'b0;
    grant = '0;
    idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = IDW'((int'(ptr) + k) % N_REQ);
      if (req[idx]) begin
        any = 1'b1;
        grant = idx;
      end
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) ptr <= '0;
    else if (accept) ptr <= (int'(grant) == N_REQ - 1) ? '0 : grant + IDW'(1);
endmodule

// File: rtl/adder_rr_sched.sv
// adder_rr_sched: shares one registered adder among N_REQ requesters, one operation in flight
module adder_rr_sched import adder_sched_pkg::*; #(
  parameter int N_REQ = N_REQ_DEF,
  parameter int DW = DW_DEF,
  parameter int ADD_LAT = 1,
  parameter int IDW = $clog2(N_REQ)
) (
  input  logic clk,
  input  logic reset,
  adder_rr_sched_if.slave bus,
  output logic busy,
  output logic [15:0] ops_done
);
  localparam int CW = $clog2(ADD_LAT + 1);
  if (ADD_LAT < 1) begin : g_lat_chk
    $error("ADD_LAT must be >= 1");
  end
  sched_state_e state, state_n;
  logic any, accept, done;
  logic [IDW-1:0] grant, id_q;
  logic [DW-1:0] a_q, b_q;
  logic [CW-1:0] cnt;
  rr_arbiter #(.N_REQ(N_REQ), .IDW(IDW)) u_arb (
    .clk(clk), .reset(reset), .req(bus.req_valid), .accept(accept), .any(any), .grant(grant)
  );
  always_comb begin
    accept = state == IDLE && any;
    done = state == WAIT && cnt == CW'(1);
    state_n = state == IDLE  ? (any ? ISSUE : IDLE) :
              state == ISSUE ? WAIT :
              state == WAIT  ? (done ? RESP : WAIT) :
                               (bus.rsp_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      a_q <= '0;
      b_q <= '0;
      id_q <= '0;
      cnt <= '0;
      bus.rsp_c <= '0;
      bus.rsp_id <= '0;
      ops_done <= '0;
    end else begin
      if (accept) begin
        a_q <= bus.req_a[grant*DW +: DW];
        b_q <= bus.req_b[grant*DW +: DW];
        id_q <= grant;
      end
      cnt <= state == ISSUE ? CW'(ADD_LAT) : state == WAIT ? cnt - CW'(1) : cnt;
      if (done) begin
        bus.rsp_c <= bus.add_c;
        bus.rsp_id <= id_q;
      end
      if (state == RESP && bus.rsp_ready) ops_done <= ops_done + 16'd1;
    end
  // reset gates the grant since IDLE alone would let it through during reset
  assign bus.req_ready = (accept && reset) ? N_REQ'(1) << grant : '0;
  assign bus.add_valid = state == ISSUE;
  assign bus.add_a = a_q;
  assign bus.add_b = b_q;
  assign bus.rsp_valid = state == RESP;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_adder_rr_sched.sv
// tb_adder_rr_sched: directed checks of grant order, latency, carry, back-pressure and reset
module tb_adder_rr_sched;
  import adder_sched_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy;
  logic [15:0] ops_done;
  int total = 0;
  int fails = 0;
  int exp_c3[4] = '{3, 6, 9, 12};
  int ids5[3] = '{3, 0, 3};
  int exp_c5[3] = '{11, 4, 11};
  rsp_t e;
  adder_rr_sched_if #(.N_REQ(4), .DW(4), .IDW(2)) bus ();
  adder_rr_sched #(.N_REQ(4), .DW(4), .ADD_LAT(1), .IDW(2)) dut (
    .clk(clk), .reset(reset), .bus(bus), .busy(busy), .ops_done(ops_done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) bus.add_c <= {1'b0, bus.add_a} + {1'b0, bus.add_b};
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
    bus.req_a[i*4 +: 4] = a;
    bus.req_b[i*4 +: 4] = b;
  endtask
  initial begin
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b1111;
    #1 reset = 1'b0;
    #1;
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_flags", {bus.add_valid, bus.rsp_valid, busy}, 0);
    chk("rst_ops", ops_done, 0);
    cyc(2);
    chk("rst_data", {bus.add_a, bus.add_b, bus.rsp_id, bus.rsp_c}, 0);
    bus.req_valid = '0;
    reset = 1'b1;
    cyc();
    // single request from requester 2
    set_op(2, 4'd3, 4'd5);
    bus.req_valid = 4'b0100;
    bus.rsp_ready = 1'b1;
    #1;
    chk("t1_grant", bus.req_ready, 4'b0100);
    chk("t1_idle_busy", busy, 0);
    cyc();
    bus.req_valid = '0;
    chk("t1_issue", {bus.add_valid, bus.add_a, bus.add_b}, {1'b1, 4'd3, 4'd5});
    chk("t1_issue_rdy", {bus.req_ready, busy}, 5'b00001);
    cyc();
    chk("t1_wait", {bus.add_valid, bus.rsp_valid, busy}, 3'b001);
    cyc();
    e = '{id: 2'd2, c: 5'd8};
    chk("t1_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_c}, {1'b1, e});
    cyc();
    chk("t1_done", {bus.rsp_valid, busy}, 0);
    chk("t1_ops", ops_done, 1);
    // carry-out preserved; ptr=3 wraps to requester 0
    set_op(0, 4'd15, 4'd15);
    bus.req_valid = 4'b0001;
    #1 chk("t2_grant", bus.req_ready, 4'b0001);
    cyc();
    bus.req_valid = '0;
    cyc(2);
    chk("t2_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_c}, {1'b1, 2'd0, 5'd30});
    cyc();
    chk("t2_ops", ops_done, 2);
    // contention after a fresh reset
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    chk("t3_ops_rst", ops_done, 0);
    set_op(0, 4'd1, 4'd2);
    set_op(1, 4'd2, 4'd4);
    set_op(2, 4'd3, 4'd6);
    set_op(3, 4'd4, 4'd8);
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1 chk($sformatf("t3_grant%0d", k), bus.req_ready, 1 << (k % 4));
      cyc(3);
      chk($sformatf("t3_rsp%0d", k), {bus.rsp_valid, bus.rsp_id, bus.rsp_c},
          {1'b1, 2'(k % 4), 5'(exp_c3[k % 4])});
      if (k == 4) bus.req_valid = '0;
      cyc();
    end
    chk("t3_ops", ops_done, 5);
    // back-pressure with requesters 1 and 3 pending
    set_op(1, 4'd7, 4'd9);
    set_op(3, 4'd10, 4'd3);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b1010;
    #1 chk("t4_grant", bus.req_ready, 4'b0010);
    cyc(3);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("t4_hold%0d", k), {bus.rsp_valid, bus.rsp_id, bus.rsp_c, bus.req_ready, busy},
          {1'b1, 2'd1, 5'd16, 4'd0, 1'b1});
      cyc();
    end
    bus.rsp_ready = 1'b1;
    cyc();
    chk("t4_next", bus.req_ready, 4'b1000);
    chk("t4_ops", ops_done, 6);
    cyc(3);
    chk("t4_rsp3", {bus.rsp_valid, bus.rsp_id, bus.rsp_c}, {1'b1, 2'd3, 5'd13});
    bus.req_valid = '0;
    cyc();
    // requester 2 leaves ptr at 3, then only 3 and 0 request
    set_op(2, 4'd1, 4'd1);
    bus.req_valid = 4'b0100;
    #1 chk("t5_pre", bus.req_ready, 4'b0100);
    cyc();
    bus.req_valid = '0;
    cyc(3);
    set_op(0, 4'd2, 4'd2);
    set_op(3, 4'd5, 4'd6);
    bus.req_valid = 4'b1001;
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("t5_grant%0d", k), bus.req_ready, 1 << ids5[k]);
      cyc(3);
      chk($sformatf("t5_rsp%0d", k), {bus.rsp_valid, bus.rsp_id, bus.rsp_c},
          {1'b1, 2'(ids5[k]), 5'(exp_c5[k])});
      if (k == 2) bus.req_valid = '0;
      cyc();
    end
    chk("t5_ops", ops_done, 11);
    // reset while waiting on the adder
    set_op(1, 4'd2, 4'd3);
    bus.req_valid = 4'b0010;
    #1 chk("t6_grant", bus.req_ready, 4'b0010);
    cyc();
    bus.req_valid = '0;
    cyc();
    chk("t6_in_wait", busy, 1);
    reset = 1'b0;
    #1;
    chk("t6_rst", {bus.add_valid, bus.rsp_valid, busy}, 0);
    chk("t6_rst_ops", ops_done, 0);
    cyc();
    reset = 1'b1;
    cyc(3);
    chk("t6_no_stale", {bus.rsp_valid, busy}, 0);
    bus.req_valid = 4'b1010;
    #1 chk("t6_grant_ptr0", bus.req_ready, 4'b0010);
    cyc();
    bus.req_valid = '0;
    cyc(2);
    chk("t6_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_c}, {1'b1, 2'd1, 5'd5});
    cyc();
    chk("t6_ops", ops_done, 1);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
